// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stages: pcsource encodings, nop word, word width.
package pipe_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JR  = 2'b10;
    localparam logic [1:0] PCSRC_J   = 2'b11;

    localparam logic [WORD_W-1:0] NOP_INST = 32'h0;

    // Redirect targets are word addresses; the two byte-offset bits are dropped.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/pipefetch_pipeir.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag, loaded when enabled.
module pipeir
    import pipe_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [WORD_W-1:0] i_pc4,
    input  logic [WORD_W-1:0] i_inst,
    output logic [WORD_W-1:0] o_pc4,
    output logic [WORD_W-1:0] o_inst,
    output logic              o_valid
);

    logic [WORD_W-1:0] r_pc4;
    logic [WORD_W-1:0] r_inst;
    logic              r_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc4   <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_pc4   <= i_pc4;
            r_inst  <= i_inst;
            r_valid <= 1'b1;
        end
    end

    assign o_pc4   = r_pc4;
    assign o_inst  = r_inst;
    assign o_valid = r_valid;

endmodule

// File: rtl/pipefetch.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register.
// Optional PIPEFETCH_PERF_EN adds saturating fetch/stall/redirect counters.
module pipefetch
    import pipe_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              wpcir,
    input  logic [1:0]        pcsource,
    input  logic [WORD_W-1:0] bpc,
    input  logic [WORD_W-1:0] rpc,
    input  logic [WORD_W-1:0] jpc,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_inst,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] id_pc4,
    output logic [WORD_W-1:0] id_inst,
`ifdef PIPEFETCH_PERF_EN
    output logic [WORD_W-1:0] perf_fetch,
    output logic [WORD_W-1:0] perf_stall,
    output logic [WORD_W-1:0] perf_redirect,
`endif
    output logic              id_valid
);

    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_pc4;
    logic [WORD_W-1:0] w_npc;

    assign w_pc4 = r_pc + 32'd4;

    always_comb begin
        w_npc = w_pc4;
        case (pcsource)
            PCSRC_SEQ: w_npc = w_pc4;
            PCSRC_BR:  w_npc = align_word(bpc);
            PCSRC_JR:  w_npc = align_word(rpc);
            PCSRC_J:   w_npc = align_word(jpc);
            default:   w_npc = w_pc4;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (wpcir) begin
            r_pc <= w_npc;
        end
    end

    assign pc        = r_pc;
    assign imem_addr = r_pc;

    pipeir u_pipeir (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_en    (wpcir),
        .i_pc4   (w_pc4),
        .i_inst  (imem_inst),
        .o_pc4   (id_pc4),
        .o_inst  (id_inst),
        .o_valid (id_valid)
    );

`ifdef PIPEFETCH_PERF_EN
    localparam logic [WORD_W-1:0] CNT_MAX = '1;

    logic [WORD_W-1:0] r_perf_fetch;
    logic [WORD_W-1:0] r_perf_stall;
    logic [WORD_W-1:0] r_perf_redirect;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perf_fetch    <= '0;
            r_perf_stall    <= '0;
            r_perf_redirect <= '0;
        end else if (wpcir) begin
            if (r_perf_fetch != CNT_MAX)
                r_perf_fetch <= r_perf_fetch + 32'd1;
            if ((pcsource != PCSRC_SEQ) && (r_perf_redirect != CNT_MAX))
                r_perf_redirect <= r_perf_redirect + 32'd1;
        end else begin
            if (r_perf_stall != CNT_MAX)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch    = r_perf_fetch;
    assign perf_stall    = r_perf_stall;
    assign perf_redirect = r_perf_redirect;
`endif

endmodule

// File: doc/pipefetch.md
# pipefetch

Instruction-fetch (IF) stage of the five-stage pipelined CPU. It holds the program counter, drives the address of the combinational instruction ROM, and selects the next PC from four sources. It latches the returned instruction together with PC+4 into the IF/ID pipeline register that feeds the decode stage. Branches and jumps are resolved in ID with one architectural delay slot, so the fetch stage never flushes.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clock  in  1  rising-edge clock for all state.
- reset  in  1  asynchronous, active-high reset.
- wpcir  in  1  write enable for PC and IF/ID register; 0 = load-use stall from ID.
- pcsource  in  2  next-PC select from ID: 00 PC+4, 01 bpc, 10 rpc, 11 jpc.
- bpc  in  32  branch target computed in ID.
- rpc  in  32  register target (jr) from ID.
- jpc  in  32  jump target (j/jal) from ID.
- imem_addr  out  32  byte address to instruction ROM; equals pc.
- imem_inst  in  32  instruction word returned combinationally by the ROM.
- pc  out  32  current fetch PC.
- id_pc4  out  32  registered PC+4 of the instruction in ID.
- id_inst  out  32  registered instruction for ID.
- id_valid  out  1  IF/ID holds a fetched instruction (0 only before the first fetch).

## Operation
- npc = pcsource-selected value; bits [1:0] of bpc/rpc/jpc are forced to 0 before loading.
- pc4 = pc + 32'd4, computed modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.
- wpcir=1 at the edge: pc <= npc; id_inst <= imem_inst; id_pc4 <= pc4; id_valid <= 1.
- wpcir=0 at the edge: pc, id_inst, id_pc4 and id_valid all hold. pcsource and the targets are ignored.
- Delay slot: a redirect asserted while instruction X is in ID takes effect for the fetch after X+4. The instruction at X+4 is latched normally, and no bubble is inserted.
- The block has no internal FSM. The state is PC, IF/ID and the optional counters.

## Timing
- Reset (asynchronous, any time, including mid-stall): pc=RESET_PC, id_inst=32'h0 (nop), id_pc4=0, id_valid=0, all counters 0.
- imem_addr follows pc combinationally, giving a zero-cycle ROM read. id_inst is valid one cycle after pc presents the address.
- Latency from pcsource redirect to new pc: 1 clock.
- If reset is released and the first edge arrives with wpcir=0, the PC stays at RESET_PC and id_valid stays 0.
- Redirect plus stall in the same cycle: the stall wins. ID must hold pcsource stable until wpcir=1.

## Configuration
- PIPEFETCH_PERF_EN defined: adds three output ports:
  - perf_fetch (32-bit): increments on every edge with wpcir=1.
  - perf_stall (32-bit): increments on every edge with wpcir=0.
  - perf_redirect (32-bit): increments on every edge with wpcir=1 and pcsource!=00.
  - All three counters saturate at 32'hFFFF_FFFF and are cleared by reset.
- PIPEFETCH_PERF_EN undefined: the ports and counters are absent. Fetch behaviour is identical.

## Structure
- Shared package (pipe_pkg) holds:
  - the pcsource encodings: PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_JR=2'b10, PCSRC_J=2'b11;
  - NOP_INST=32'h0;
  - the 32-bit word width constant.
- One sub-module, pipeir: the IF/ID register (enable, asynchronous reset, pc4/inst/valid). The PC register and next-PC mux stay in pipefetch.

## Test plan
- Reset then 3 clocks with wpcir=1, pcsource=00, ROM program loaded: pc sequence 0→4→8→0xC. id_inst sequence 3c010000, 34240050, 0c00001b. id_valid rises after the first edge.
- jal at 0x08: while id_inst=0c00001b, drive pcsource=11 and jpc=0x6c. Next edge: id_inst=20050004 (delay slot at 0x0c), pc=0x6c. Following edge: id_inst=00004020.
- Stall: wpcir=0 for 2 cycles with pc=0x70. pc, id_inst and id_pc4 are unchanged. With PIPEFETCH_PERF_EN, perf_stall increases by 2.
- jr and branch: pcsource=10 with rpc=0x13 gives pc=0x10 (low bits forced). pcsource=01 with bpc=0x54 gives pc=0x54.
- Wrap: force pc to 32'hFFFF_FFFC via a jump and run pcsource=00. Next pc=0 and id_pc4=0.
- Asynchronous reset asserted mid-cycle during a stall: outputs return to reset values immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC.
